// File: rtl/registru_mant_align_pkg.sv
// Shared definitions for the FP-adder mantissa register: shift-mode and
// FSM-state encodings plus a helper that folds the reserved mode code.
package registru_mant_align_pkg;

    typedef enum logic [1:0] {
        MODE_RIGHT = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_NORM  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Map the raw 2-bit mode input onto a legal mode; 11 behaves as right shift.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b01:   m = MODE_LEFT;
            2'b10:   m = MODE_NORM;
            default: m = MODE_RIGHT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/registru_mant_align_contor_shift.sv
// Down-counter holding the remaining shift amount. Loaded with the requested
// amount, decremented once per shift; tc flags that the next decrement is the
// final one (count == 1). Also usable by the exponent-difference logic.
module contor_shift #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Remaining-count register: reset/clear, load, decrement-to-zero, hold.
    always_ff @(posedge clk) begin
        if (!clear_n || clear) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == CNT_ONE);

endmodule

// File: rtl/registru_mant_align.sv
// Mantissa register for the FP adder datapath: load/clear plus a serial
// one-bit-per-clock shift engine (right align with G/R/S, left, normalise).
module registru_mant_align
    import registru_mant_align_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               clear,
    input  logic               load,
    input  logic [WIDTH-1:0]   mantisa,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   saved_mant,
    output logic               guard,
    output logic               round,
    output logic               sticky,
    output logic [SHAMT_W-1:0] shift_count,
    output logic               busy,
    output logic               done,
    output logic               zero
);

    localparam logic [WIDTH-1:0]   MANT_ZERO = {WIDTH{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ZERO  = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE   = {{(SHAMT_W-1){1'b0}}, 1'b1};
    // Normalisation gives up once WIDTH shifts have been made (all-zero input).
    localparam logic [SHAMT_W-1:0] NORM_LAST = SHAMT_W'(WIDTH - 1);

    state_e             state_r;
    mode_e              mode_r;
    logic [WIDTH-1:0]   mant_r;
    logic               g_r;
    logic               r_r;
    logic               s_r;
    logic [SHAMT_W-1:0] count_r;
    logic               busy_r;
    logic               done_r;

    mode_e              mode_s;
    logic               start_ok_s;
    logic               start_zero_s;
    logic               cnt_dec_s;
    logic               cnt_tc_s;
    logic [WIDTH-1:0]   nxt_mant_s;
    logic               nxt_g_s;
    logic               nxt_r_s;
    logic               nxt_s_s;
    logic               shift_exit_s;

    assign mode_s     = decode_mode(mode);
    // load wins over start; both only matter in IDLE.
    assign start_ok_s = (state_r == ST_IDLE) && start && !load;
    assign cnt_dec_s  = (state_r == ST_SHIFT) && (mode_r != MODE_NORM);

    contor_shift #(
        .W (SHAMT_W)
    ) u_contor (
        .clk      (clk),
        .clear_n  (clear_n),
        .clear    (clear),
        .load     (start_ok_s),
        .load_val (shamt),
        .dec      (cnt_dec_s),
        .tc       (cnt_tc_s)
    );

    // Decide whether an accepted start needs no shifting at all.
    always_comb begin
        start_zero_s = 1'b0;
        if (mode_s == MODE_NORM) begin
            start_zero_s = mant_r[WIDTH-1];
        end else begin
            start_zero_s = (shamt == CNT_ZERO);
        end
    end

    // One shift step of the mantissa and its extension bits for the latched mode.
    always_comb begin
        nxt_mant_s = mant_r;
        nxt_g_s    = g_r;
        nxt_r_s    = r_r;
        nxt_s_s    = s_r;
        case (mode_r)
            MODE_RIGHT: begin
                nxt_s_s    = s_r | r_r;
                nxt_r_s    = g_r;
                nxt_g_s    = mant_r[0];
                nxt_mant_s = {1'b0, mant_r[WIDTH-1:1]};
            end
            MODE_LEFT, MODE_NORM: begin
                nxt_mant_s = {mant_r[WIDTH-2:0], g_r};
                nxt_g_s    = r_r;
                nxt_r_s    = 1'b0;
            end
            default: begin
                nxt_mant_s = mant_r;
            end
        endcase
    end

    // Decide whether the step being taken now is the last one.
    always_comb begin
        shift_exit_s = 1'b0;
        if (mode_r == MODE_NORM) begin
            shift_exit_s = nxt_mant_s[WIDTH-1] || (count_r == NORM_LAST);
        end else begin
            shift_exit_s = cnt_tc_s;
        end
    end

    // Control FSM and datapath registers; reset and clear abort everything.
    always_ff @(posedge clk) begin
        if (!clear_n || clear) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_RIGHT;
            mant_r  <= MANT_ZERO;
            g_r     <= 1'b0;
            r_r     <= 1'b0;
            s_r     <= 1'b0;
            count_r <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (load) begin
                        mant_r <= mantisa;
                        g_r    <= 1'b0;
                        r_r    <= 1'b0;
                        s_r    <= 1'b0;
                    end else if (start) begin
                        mode_r  <= mode_s;
                        count_r <= CNT_ZERO;
                        if (start_zero_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_SHIFT;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    mant_r  <= nxt_mant_s;
                    g_r     <= nxt_g_s;
                    r_r     <= nxt_r_s;
                    s_r     <= nxt_s_s;
                    count_r <= count_r + CNT_ONE;
                    if (shift_exit_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                        busy_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign saved_mant  = mant_r;
    assign guard       = g_r;
    assign round       = r_r;
    assign sticky      = s_r;
    assign shift_count = count_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign zero        = (mant_r == MANT_ZERO);

endmodule

// File: doc/registru_mant_align.md
Name: registru_mant_align

Overview:
- Parametrised mantissa register for the FP adder datapath.
- Generalises the plain clear/load mantissa register: configurable width, plus a multi-cycle serial shift engine.
- Shift modes: right alignment with guard/round/sticky capture, left shift, and normalise (shift left until MSB=1), one bit per clock.
- Sits between exponent-compare/alignment and the adder, and after the adder for post-normalisation.

Parameters:
- WIDTH, 24, mantissa width in bits (including hidden bit).
- SHAMT_W, 5, width of shamt and shift_count; 2^SHAMT_W must exceed WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- clear_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous active-high datapath clear (functional, not reset).
- load  in  1  load mantisa when idle.
- mantisa  in  WIDTH  mantissa to load.
- start  in  1  begin shift operation when idle.
- mode  in  2  00 shift right, 01 shift left, 10 normalise, 11 reserved (treated as 00).
- shamt  in  SHAMT_W  shift amount for modes 00/01; ignored in 10.
- saved_mant  out  WIDTH  register contents.
- guard, round, sticky  out  1 each  extension bits below the LSB.
- shift_count  out  SHAMT_W  shifts performed in the last/current operation.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse when an operation completes.
- zero  out  1  combinational, saved_mant == 0.

Behaviour:
- Reset: clear_n=0 at a rising edge forces saved_mant=0, guard=round=sticky=0, shift_count=0, busy=0, done=0, FSM=IDLE. Reset has priority over everything.
- clear=1 (with clear_n=1), in any state: same effect as reset. Aborts an in-flight shift; no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load=1 → saved_mant<=mantisa, G/R/S<=0. load has priority over start.
  - start=1 and load=0 → latch mode, remaining=shamt, shift_count<=0.
  - Modes 00/01 with shamt=0, or mode 10 with saved_mant[WIDTH-1]=1 → go to DONE; otherwise go to SHIFT.
- SHIFT (busy=1), one shift per cycle, shift_count increments by 1:
  - Right: sticky<=sticky|round; round<=guard; guard<=mant[0]; mant<=mant>>1 (MSB filled with 0).
  - Left: mant<=(mant<<1)|guard; guard<=round; round<=0; sticky unchanged.
  - Normalise: left-shift step, repeated until the MSB of the post-shift value is 1 or shift_count reaches WIDTH.
  - Modes 00/01 exit after shamt shifts. Exit target is DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- load and start are ignored in SHIFT and DONE; no queuing.
- Latency: start accepted at edge 0; shift of N takes edges 1..N; done is high in the cycle after edge N (N=0 → done in the cycle after edge 0).
- shift_count holds its value until the next accepted start or clear.
- shamt ≥ WIDTH+3 (right): all set bits end in sticky; mant=guard=round=0.
- Normalise of all-zero input: exactly WIDTH shifts, shift_count=WIDTH, zero=1.

Decomposition:
- Shared include file (fp_defs.vh): mode encodings (MODE_RIGHT, MODE_LEFT, MODE_NORM) and FSM state encodings.
- One natural sub-module: contor_shift — SHAMT_W-bit down-counter with load/decrement/terminal-count, reused by the exponent-difference logic.

Test Plan:
- Reset: drive clear_n=0 with garbage inputs → all outputs 0, busy=0, done=0; load ignored during reset.
- Right shift: load 24'hC00001; start mode 00, shamt=3 → busy 3 cycles, then done; saved_mant=24'h180000, guard=0, round=0, sticky=1, shift_count=3.
- Normalise: load 24'h000F00; start mode 10 → 12 busy cycles; saved_mant=24'hF00000, shift_count=12, done pulse once.
- Normalise zero: load 0; start mode 10 → 24 shifts, shift_count=24, zero=1, saved_mant=0.
- Abort and ignore: start mode 00, shamt=10. At shift 4, pulse load with 24'hABCDEF → ignored. At shift 6, pulse clear → all zero, IDLE, no done.
- Zero shift and priority: start shamt=0 → done the next cycle, saved_mant unchanged. load=1 and start=1 together in IDLE → load wins, no shift.
